fp16_mul_arbiter: RTL



---
 rtl/fp16_mul_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shares one pipelined fp16 multiplier between N_REQ requesters.
// One operation in flight; a request is latched in IDLE, issued in ISSUE, and the
// product is captured after MUL_LAT WAIT cycles and returned with a one-cycle pulse.
// Optional build macro MUL_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin arbitration.
module fp16_mul_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [15:0]           rsp_data,
  output logic                  busy,
  output logic                  mul_err,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  output logic                  mul_en,
  input  logic [15:0]           mul_out,
  input  logic                  mul_ready
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_t;

  arbState_t          state;
  arbState_t          stateNext;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   gntNext;
  logic [CNT_W-1:0]   waitCnt;
  logic [CNT_W-1:0]   waitCntNext;
  logic [IDX_W-1:0]   searchBase;
  logic               winFound;
  logic [IDX_W-1:0]   winIdx;

  logic [N_REQ-1:0]   reqReadyNext;
  logic [N_REQ-1:0]   rspValidNext;
  logic [DATA_W-1:0]  rspDataNext;
  logic               busyNext;
  logic               mulErrNext;
  logic [DATA_W-1:0]  mulANext;
  logic [DATA_W-1:0]  mulBNext;
  logic               mulEnNext;

  logic [DATA_W-1:0]  opA [N_REQ];
  logic [DATA_W-1:0]  opB [N_REQ];

  // Unpack the flat operand buses into per-requester words
  for (genvar g = 0; g < N_REQ; g++) begin : gUnpack
    assign opA[g] = req_a[DATA_W*g +: DATA_W];
    assign opB[g] = req_b[DATA_W*g +: DATA_W];
  end

`ifdef MUL_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0
  assign searchBase = '0;
`else
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   rrPtrNext;

  assign searchBase = rrPtr;

  // Round-robin pointer advances only when an operation completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rrPtr <= '0;
    else     rrPtr <= rrPtrNext;
  end
`endif

  // Index reached after stepping 'off' places upward from 'base', wrapping at N_REQ
  function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDX_W'(sum % N_REQ);
  endfunction

  // Winner search: first pending requester at or above searchBase, with wrap
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!winFound && req_valid[wrapIdx(searchBase, i)]) begin
        winFound = 1'b1;
        winIdx   = wrapIdx(searchBase, i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and next-output logic; outputs are registered one cycle ahead
  always_comb begin
    stateNext    = state;
    gntNext      = gnt;
    waitCntNext  = waitCnt;
    reqReadyNext = '0;
    rspValidNext = '0;
    rspDataNext  = rsp_data;
    mulErrNext   = mul_err;
    mulANext     = mul_a;
    mulBNext     = mul_b;
    mulEnNext    = 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
    rrPtrNext    = rrPtr;
`endif
    unique case (state)
      IDLE: begin
        if (winFound) begin
          mulANext             = opA[winIdx];
          mulBNext             = opB[winIdx];
          gntNext              = winIdx;
          mulEnNext            = 1'b1;
          reqReadyNext[winIdx] = 1'b1;
          stateNext            = ISSUE;
        end
      end
      ISSUE: begin
        waitCntNext = CNT_W'(MUL_LAT);
        stateNext   = WAIT;
      end
      WAIT: begin
        waitCntNext = waitCnt - CNT_W'(1);
        if (waitCnt == CNT_W'(1)) begin
          rspDataNext       = mul_out;
          mulErrNext        = mul_err | ~mul_ready;
          rspValidNext[gnt] = 1'b1;
`ifndef MUL_ARB_FIXED_PRIO_EN
          rrPtrNext         = (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + IDX_W'(1);
`endif
          stateNext         = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      waitCnt   <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      mul_err   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_en    <= 1'b0;
    end else begin
      gnt       <= gntNext;
      waitCnt   <= waitCntNext;
      req_ready <= reqReadyNext;
      rsp_valid <= rspValidNext;
      rsp_data  <= rspDataNext;
      busy      <= busyNext;
      mul_err   <= mulErrNext;
      mul_a     <= mulANext;
      mul_b     <= mulBNext;
      mul_en    <= mulEnNext;
    end
  end

endmodule
